// File: rtl/mult_hilo_controller.sv
// Execute-stage sequencer for the shared iterative multiplier; owns the HI/LO registers
// and raises a stall only when a dependent instruction meets an in-flight multiply.
module mult_hilo_controller #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mult_e,
    input  logic               mult_signed_e,
    input  logic               mfhi_e,
    input  logic               mflo_e,
    input  logic [WIDTH-1:0]   srca_e,
    input  logic [WIDTH-1:0]   srcb_e,
    input  logic               mul_ready,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               mul_start,
    output logic               mul_signed,
    output logic [WIDTH-1:0]   mul_src_a,
    output logic [WIDTH-1:0]   mul_src_b,
    output logic               stall_mult,
    output logic [WIDTH-1:0]   hilo_rdata,
    output logic               busy,
    output logic               err_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]  src_a_q, src_a_d, src_b_q, src_b_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    assign busy        = (state_q != StIdle);
    assign mul_start   = (state_q == StIssue);
    assign mul_signed  = signed_q;
    assign mul_src_a   = src_a_q;
    assign mul_src_b   = src_b_q;
    assign err_timeout = err_q;
    assign hilo_rdata  = mfhi_e ? hi_q : lo_q;

    // A MULT may also wait in IDLE while the multiplier itself is not ready.
    assign stall_mult = ((mult_e | mfhi_e | mflo_e) & busy) | (mult_e & ~busy & ~mul_ready);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        signed_d = signed_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mult_e && mul_ready && !stall_mult) begin
                    src_a_d  = srca_e;
                    src_b_d  = srcb_e;
                    signed_d = mult_signed_e;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (mul_done) begin
                    hi_d    = mul_product[2*WIDTH-1:WIDTH];
                    lo_d    = mul_product[WIDTH-1:0];
                    state_d = StIdle;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            lo_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mult_hilo_controller.sv
// Directed and randomized bench for mult_hilo_controller; the bench plays the multiplier
// and predicts HI/LO from the operands it issued using plain 64-bit arithmetic.
module tb_mult_hilo_controller;

    localparam int W  = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          mult_e, mult_signed_e, mfhi_e, mflo_e;
    logic [W-1:0]  srca_e, srcb_e;
    logic          mul_ready, mul_done;
    logic [2*W-1:0] mul_product;
    logic          mul_start, mul_signed, stall_mult, busy, err_timeout;
    logic [W-1:0]  mul_src_a, mul_src_b, hilo_rdata;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mult_hilo_controller #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .mult_e(mult_e), .mult_signed_e(mult_signed_e),
        .mfhi_e(mfhi_e), .mflo_e(mflo_e), .srca_e(srca_e), .srcb_e(srcb_e),
        .mul_ready(mul_ready), .mul_done(mul_done), .mul_product(mul_product),
        .mul_start(mul_start), .mul_signed(mul_signed), .mul_src_a(mul_src_a),
        .mul_src_b(mul_src_b), .stall_mult(stall_mult), .hilo_rdata(hilo_rdata),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Read HI and LO through the MF* path; no multiply is in flight, so no stall.
    task automatic chk_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        mfhi_e = 1'b1;
        #1 chk("hi", hilo_rdata, h);
        chk("mf_nostall", stall_mult, 0);
        mfhi_e = 1'b0;
        mflo_e = 1'b1;
        #1 chk("lo", hilo_rdata, l);
        mflo_e = 1'b0;
    endtask

    // Full multiply with done sampled `delay` cycles after the start pulse.
    task automatic mult_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int delay);
        mult_e = 1'b1; mult_signed_e = s; srca_e = a; srcb_e = b; mul_ready = 1'b1;
        #1 chk("accept_nostall", stall_mult, 0);
        next();
        mult_e = 1'b0; srca_e = $urandom; srcb_e = $urandom; mult_signed_e = ~s;
        #1 chk("start_pulse", mul_start, 1);
        chk("src_a", mul_src_a, a);
        chk("src_b", mul_src_b, b);
        chk("signed", mul_signed, s);
        for (int i = 0; i < delay; i++) begin
            next();
            chk("start_low", mul_start, 0);
            chk("busy_wait", busy, 1);
            chk("wait_nostall", stall_mult, 0);
            if (i == delay - 1) begin
                mul_done = 1'b1;
                mul_product = prod(mul_src_a, mul_src_b, mul_signed);
            end
        end
        next();
        mul_done = 1'b0;
        {exp_hi, exp_lo} = prod(a, b, s);
        #1 chk("busy_done", busy, 0);
        chk_hilo(exp_hi, exp_lo);
    endtask

    initial begin
        reset = 1'b0; mult_e = 0; mult_signed_e = 0; mfhi_e = 0; mflo_e = 0;
        srca_e = '0; srcb_e = '0; mul_ready = 1'b1; mul_done = 1'b0; mul_product = '0;
        next();
        chk("rst_busy", busy, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_src_a", mul_src_a, 0);
        chk("rst_signed", mul_signed, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_stall", stall_mult, 0);
        chk_hilo(0, 0);
        next();
        reset = 1'b1;

        // Unsigned multiply, done 4 cycles after start
        next();
        mult_op(32'hFFFF_FFFF, 32'd2, 1'b0, 4);
        chk("multu_hi", exp_hi, 32'h1);
        chk("multu_lo", exp_lo, 32'hFFFF_FFFE);

        // Signed multiply with MFLO waiting behind it
        next();
        mult_e = 1'b1; mult_signed_e = 1'b1; srca_e = -32'sd3; srcb_e = 32'sd7;
        next();
        mult_e = 1'b0; mflo_e = 1'b1;
        #1 chk("mflo_stall_issue", stall_mult, 1);
        for (int i = 0; i < 3; i++) begin
            next();
            chk("mflo_stall_wait", stall_mult, 1);
            chk("no_bypass", hilo_rdata, exp_lo);
            if (i == 2) begin
                mul_done = 1'b1;
                mul_product = prod(mul_src_a, mul_src_b, mul_signed);
            end
        end
        next();
        mul_done = 1'b0;
        #1 chk("mflo_unstall", stall_mult, 0);
        chk("mflo_value", hilo_rdata, 32'hFFFF_FFEB);
        mflo_e = 1'b0;
        chk_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Back-to-back MULT
        next();
        mult_e = 1'b1; mult_signed_e = 1'b0; srca_e = 32'd5; srcb_e = 32'd6;
        #1 chk("b2b_first_accept", stall_mult, 0);
        next();
        srca_e = 32'd7; srcb_e = 32'd8;
        #1 chk("b2b_stall_issue", stall_mult, 1);
        chk("b2b_src_a_hold", mul_src_a, 5);
        next();
        chk("b2b_stall_wait", stall_mult, 1);
        mul_done = 1'b1;
        mul_product = prod(mul_src_a, mul_src_b, mul_signed);
        next();
        mul_done = 1'b0;
        #1 chk("b2b_idle_nostall", stall_mult, 0);
        chk("b2b_first_lo", hilo_rdata, 30);
        chk("b2b_src_b_hold", mul_src_b, 6);
        next();
        mult_e = 1'b0;
        #1 chk("b2b_start2", mul_start, 1);
        chk("b2b_src_a2", mul_src_a, 7);
        chk("b2b_src_b2", mul_src_b, 8);
        next();
        mul_done = 1'b1;
        mul_product = prod(mul_src_a, mul_src_b, mul_signed);
        next();
        mul_done = 1'b0;
        chk_hilo(0, 56);

        // Multiplier not ready, then timeout
        next();
        mult_e = 1'b1; mul_ready = 1'b0; srca_e = 32'd9; srcb_e = 32'd9;
        #1 chk("nrdy_stall", stall_mult, 1);
        next();
        chk("nrdy_no_start", mul_start, 0);
        chk("nrdy_idle", busy, 0);
        mul_ready = 1'b1;
        #1 chk("rdy_nostall", stall_mult, 0);
        next();
        mult_e = 1'b0;
        #1 chk("to_start", mul_start, 1);
        for (int i = 0; i < TO; i++) begin
            next();
            chk("to_busy", busy, 1);
            chk("to_err_low", err_timeout, 0);
        end
        next();
        chk("to_idle", busy, 0);
        chk("to_err", err_timeout, 1);
        chk_hilo(0, 56);

        // Reset in the middle of WAIT
        next();
        mult_e = 1'b1; mult_signed_e = 1'b0; srca_e = 32'd11; srcb_e = 32'd13;
        next();
        mult_e = 1'b0;
        next();
        next();
        mfhi_e = 1'b1;
        reset = 1'b0;
        #1 chk("mid_rst_busy", busy, 0);
        chk("mid_rst_stall", stall_mult, 0);
        chk("mid_rst_start", mul_start, 0);
        chk("mid_rst_hi", hilo_rdata, 0);
        chk("mid_rst_err", err_timeout, 0);
        mfhi_e = 1'b0;
        next();
        reset = 1'b1;
        mul_done = 1'b1;
        mul_product = 64'h1234_5678_9ABC_DEF0;
        next();
        mul_done = 1'b0;
        #1 chk("late_done_busy", busy, 0);
        exp_hi = '0; exp_lo = '0;
        chk_hilo(exp_hi, exp_lo);

        // Randomized multiplies against the arithmetic model
        for (int n = 0; n < 16; n++) begin
            next();
            mult_op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_hilo_controller.md
Name: mult_hilo_controller

Overview:
Sequences the shared iterative `multiplier` for MULT/MULTU instructions in the execute stage and owns the architectural HI/LO registers. It captures the operands at issue, pulses start and waits for done, and the pipeline keeps running meanwhile. It raises a stall to the hazard unit only when an MFHI, MFLO or second MULT reaches execute while a multiply is still in flight. It also drives the HI/LO read value that feeds the execute-stage output mux.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
TIMEOUT, 64, maximum cycles in WAIT before abort; must be at least 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mult_e  in  1  MULT/MULTU in execute stage
mult_signed_e  in  1  1 = MULT (signed), 0 = MULTU
mfhi_e  in  1  MFHI in execute stage
mflo_e  in  1  MFLO in execute stage
srca_e  in  WIDTH  forwarded operand A
srcb_e  in  WIDTH  forwarded operand B
mul_ready  in  1  multiplier idle and able to accept start
mul_done  in  1  multiplier result valid (pulse)
mul_product  in  2*WIDTH  multiplier result
mul_start  out  1  one-cycle start pulse
mul_signed  out  1  registered signed flag
mul_src_a  out  WIDTH  registered operand A
mul_src_b  out  WIDTH  registered operand B
stall_mult  out  1  stall request to hazard unit (holds F/D/E)
hilo_rdata  out  WIDTH  HI if mfhi_e, else LO
busy  out  1  state != IDLE
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async) forces the following values:
  - state = IDLE;
  - HI = LO = 0;
  - mul_start = 0, mul_signed = 0, mul_src_a = mul_src_b = 0;
  - err_timeout = 0, wait counter = 0.
- Reset mid-operation abandons the multiply. It does not reset the multiplier; that block has its own reset on the same net.
- States:
  - IDLE:
    - If mult_e && mul_ready && !stall_mult: register srca_e, srcb_e and mult_signed_e, then go to ISSUE.
    - mult_e has priority if mfhi_e or mflo_e is asserted at the same time.
  - ISSUE: mul_start=1 for exactly this cycle. mul_done is ignored here. Clear the counter and go to WAIT.
  - WAIT:
    - mul_start=0. The counter increments each cycle.
    - If mul_done is sampled 1: HI <= mul_product[2W-1:W], LO <= mul_product[W-1:0], go to IDLE.
    - Otherwise, if the counter reaches TIMEOUT-1: err_timeout <= 1, HI/LO unchanged, go to IDLE.
- Timing:
  - Accept at cycle T; mul_start is high in T+1.
  - HI/LO update on the edge at which mul_done is sampled high in WAIT, and are visible from the next cycle.
  - Minimum accept-to-HI/LO-visible latency is 3 cycles.
- stall_mult is combinational:
  - It is 1 when (mult_e | mfhi_e | mflo_e) && busy.
  - It is also 1 when mult_e && !busy && !mul_ready.
  - It is 0 otherwise; no stall for any other instruction.
- The multiply is accepted, and the MULT leaves execute, in the same cycle: the cycle with mult_e=1 and stall_mult=0.
- mul_src_a, mul_src_b and mul_signed are held stable from accept until the next accept. Later forwarding changes do not disturb them.
- hilo_rdata is combinational from the HI/LO registers. There is no bypass of mul_product: a MFHI/MFLO stalled on a pending multiply reads the new value in its first unstalled cycle.
- After a timeout, HI/LO hold their old values. A following MFHI/MFLO reads those stale values without stalling. err_timeout clears only on reset.
- Back-to-back MULT: the second MULT stalls through ISSUE and WAIT, then is accepted in the first IDLE cycle.

Test Plan:
- Unsigned multiply: reset release; MULTU with srca=0xFFFFFFFF, srcb=2; model mul_done 4 cycles after start -> mul_start is a single pulse at T+1, then HI=0x00000001, LO=0xFFFFFFFE, and stall_mult stays 0 while no MF* is in execute.
- Signed multiply with waiting MFLO: MULT srca=-3, srcb=7, then MFLO in the next cycle -> stall_mult=1 until HI/LO update; hilo_rdata=0xFFFFFFEB (LO) in the first unstalled cycle; HI=0xFFFFFFFF.
- Back-to-back MULT: 5×6 then 7×8 -> the second stalls until IDLE; operands are latched only at its accept; final LO=56, HI=0.
- Multiplier not ready: mul_ready=0 in IDLE with mult_e=1 -> stall_mult=1, no mul_start; raise mul_ready -> accept the same cycle.
- Timeout: mul_done is never asserted -> err_timeout=1 after TIMEOUT cycles in WAIT; HI/LO keep the prior values (e.g. LO=56); busy=0; the following MFHI does not stall.
- Reset mid-multiply: assert reset during WAIT -> immediately state IDLE, HI=LO=0, stall_mult=0, mul_start=0; a mul_done arriving after reset release has no effect.
